// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and helpers for the UART receiver
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_COMMIT,
    ST_BRK
  } state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clock cycles per line bit (integer division).
  function automatic int bit_period(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - receive word FIFO with registered storage and head read-out
module uart_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] wdata_in,
  input  logic             pop_in,
  output logic [WIDTH-1:0] rdata_out,
  output logic             full_out,
  output logic             empty_out
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign empty_out = (wptr_q == rptr_q);
  assign full_out  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign do_pop    = pop_in && !empty_out;
  assign do_push   = push_in && (!full_out || do_pop);
  assign rdata_out = empty_out ? '0 : mem_q[rptr_q[AW-1:0]];

  // Next-state for storage and pointers.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = wdata_in;
      wptr_d = wptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: rtl/uart_receive_cfg.sv
// rtl/uart_receive_cfg.sv - configurable UART receiver with majority sampling and word FIFO
module uart_receive_cfg
  import uart_pkg::*;
#(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 57600,
  parameter int DATA_BITS        = 8,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rx_wire_in,
  output logic [DATA_BITS-1:0] data_byte_out,
  output logic                 parity_err_out,
  output logic                 frame_err_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 overrun_out,
  output logic                 break_out,
  output logic                 busy_out
);

  localparam int BP = bit_period(INPUT_CLOCK_FREQ, BAUD_RATE);
  localparam int CW = $clog2(BP);
  localparam logic [CW-1:0] CNT_MAX = CW'(BP - 1);
  localparam logic [CW-1:0] SMP_0   = CW'(BP/2 - 1);
  localparam logic [CW-1:0] SMP_1   = CW'(BP/2);
  localparam logic [CW-1:0] SMP_2   = CW'(BP/2 + 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (BP < 4) begin : g_bad_bit_period
    $error("bit period must be at least 4 clocks");
  end

  state_e               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic                 prev_q, prev_d;
  logic                 seen_q, seen_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 par_bit_q, par_bit_d;
  logic                 brk_q, brk_d;
  logic                 brk_pulse_q, brk_pulse_d;

  logic                 line, maj, decide, brk_now, hold_cnt;
  logic                 push, pop, fifo_full, fifo_empty;
  logic [DATA_BITS+1:0] fifo_rdata;

  assign line   = sync_q[1];
  assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & line) | (samp_q[1] & line);
  assign decide = (cnt_q == SMP_2);

  // Frame FSM next-state, bit timing, sampling and datapath.
  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], rx_wire_in};
    prev_d      = line;
    seen_d      = seen_q | line;
    samp_d      = samp_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    par_err_d   = par_err_q;
    frm_err_d   = frm_err_q;
    par_bit_d   = par_bit_q;
    brk_now     = brk_q;
    brk_d       = brk_q;

    if (cnt_q == SMP_0) samp_d[0] = line;
    if (cnt_q == SMP_1) samp_d[1] = line;

    case (state_q)
      ST_IDLE: begin
        if (seen_q && prev_q && !line) state_d = ST_START;
      end
      ST_START: begin
        if (decide) begin
          if (!maj) begin
            state_d    = ST_DATA;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            par_err_d  = 1'b0;
            frm_err_d  = 1'b0;
            par_bit_d  = 1'b0;
            brk_d      = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (decide) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == 4'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
            state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (decide) begin
          par_bit_d = maj;
          par_err_d = (PARITY == PARITY_ODD) ? !(^shift_q ^ maj) : (^shift_q ^ maj);
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (decide) begin
          if (!maj) frm_err_d = 1'b1;
          if (stop_idx_q == 1'b0) begin
            brk_now = (shift_q == '0) && !par_bit_q && !maj;
            brk_d   = brk_now;
          end
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            state_d = brk_now ? ST_BRK : ST_COMMIT;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      ST_BRK: begin
        if (line) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    brk_pulse_d = (state_q == ST_STOP) && (state_d == ST_BRK);

    hold_cnt = (state_q == ST_IDLE) || (state_q == ST_COMMIT) || (state_q == ST_BRK) ||
               (state_d == ST_IDLE) || (state_d == ST_COMMIT) || (state_d == ST_BRK);
    if (hold_cnt)               cnt_d = '0;
    else if (cnt_q == CNT_MAX)  cnt_d = '0;
    else                        cnt_d = cnt_q + CW'(1);
  end

  // State, synchronizer and datapath registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      sync_q      <= 2'b11;
      prev_q      <= 1'b1;
      seen_q      <= 1'b0;
      cnt_q       <= '0;
      samp_q      <= '0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      par_bit_q   <= 1'b0;
      brk_q       <= 1'b0;
      brk_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      seen_q      <= seen_d;
      cnt_q       <= cnt_d;
      samp_q      <= samp_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      par_err_q   <= par_err_d;
      frm_err_q   <= frm_err_d;
      par_bit_q   <= par_bit_d;
      brk_q       <= brk_d;
      brk_pulse_q <= brk_pulse_d;
    end
  end

  assign push        = (state_q == ST_COMMIT);
  assign pop         = valid_out && ready_in;
  assign valid_out   = !fifo_empty;
  assign overrun_out = push && fifo_full && !pop;
  assign break_out   = brk_pulse_q;
  assign busy_out    = (state_q != ST_IDLE);
  assign {frame_err_out, parity_err_out, data_byte_out} = fifo_rdata;

  uart_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push_in   (push),
    .wdata_in  ({frm_err_q, par_err_q, shift_q}),
    .pop_in    (pop),
    .rdata_out (fifo_rdata),
    .full_out  (fifo_full),
    .empty_out (fifo_empty)
  );

endmodule

// File: tb/tb_uart_receive_cfg.sv
// tb/tb_uart_receive_cfg.sv - scoreboard bench for uart_receive_cfg at 10 clocks per bit
module tb_uart_receive_cfg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_e = 1'b1;
  logic       ready = 1'b1;

  logic [7:0] data;
  logic       perr, ferr, valid, ovr, brk, busy;
  logic [7:0] e_data;
  logic       e_perr, e_ferr, e_valid, e_ovr, e_brk, e_busy;

  int checks = 0;
  int failures = 0;
  int valid_hi = 0;
  int ovr_cnt = 0;
  int brk_cnt = 0;
  int busy_cyc = 0;
  int e_misc = 0;
  int v0, o0, b0, c0;

  logic [9:0] exp_q [$];
  logic [9:0] exp_e [$];

  always #5 clk = ~clk;

  uart_receive_cfg #(
    .INPUT_CLOCK_FREQ (1_000_000),
    .BAUD_RATE        (100_000),
    .DATA_BITS        (8),
    .PARITY           (0),
    .STOP_BITS        (1),
    .FIFO_DEPTH       (4)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .rx_wire_in     (rx),
    .data_byte_out  (data),
    .parity_err_out (perr),
    .frame_err_out  (ferr),
    .valid_out      (valid),
    .ready_in       (ready),
    .overrun_out    (ovr),
    .break_out      (brk),
    .busy_out       (busy)
  );

  uart_receive_cfg #(
    .INPUT_CLOCK_FREQ (1_000_000),
    .BAUD_RATE        (100_000),
    .DATA_BITS        (8),
    .PARITY           (2),
    .STOP_BITS        (1),
    .FIFO_DEPTH       (4)
  ) dut_e (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .rx_wire_in     (rx_e),
    .data_byte_out  (e_data),
    .parity_err_out (e_perr),
    .frame_err_out  (e_ferr),
    .valid_out      (e_valid),
    .ready_in       (1'b1),
    .overrun_out    (e_ovr),
    .break_out      (e_brk),
    .busy_out       (e_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) rx = bits[i];
      else            rx_e = bits[i];
      repeat (10) @(negedge clk);
    end
    if (which == 0) rx = 1'b1;
    else            rx_e = 1'b1;
  endtask

  task automatic send_8n1(input logic [7:0] d, input logic stop);
    send_bits(0, {6'b0, stop, d, 1'b0}, 10);
  endtask

  // Scoreboard monitor for the 8N1 instance plus pulse/occupancy counters.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) valid_hi++;
      if (ovr)   ovr_cnt++;
      if (brk)   brk_cnt++;
      if (busy)  busy_cyc++;
      if (valid && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL mon_unexpected actual=%0h required=none", {ferr, perr, data});
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if ({ferr, perr, data} !== e) begin
            failures++;
            $display("FAIL mon_word actual=%0h required=%0h", {ferr, perr, data}, e);
          end
        end
      end
    end
  end

  // Scoreboard monitor for the even-parity instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (e_ovr || e_brk) e_misc++;
      if (e_valid) begin
        checks++;
        if (exp_e.size() == 0) begin
          failures++;
          $display("FAIL mon_e_unexpected actual=%0h required=none", {e_ferr, e_perr, e_data});
        end else begin
          logic [9:0] e;
          e = exp_e.pop_front();
          if ({e_ferr, e_perr, e_data} !== e) begin
            failures++;
            $display("FAIL mon_e_word actual=%0h required=%0h", {e_ferr, e_perr, e_data}, e);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    gap(3);
    chk("reset_outs", {valid, perr, ferr, data, ovr, brk, busy}, 0);
    chk("reset_outs_e", {e_valid, e_perr, e_ferr, e_data, e_ovr, e_brk, e_busy}, 0);
    rst_n = 1'b1;
    gap(5);
    chk("idle_busy", busy, 0);

    // Clean 8N1 frames, including all-zero data and a bad stop bit.
    v0 = valid_hi;
    exp_q.push_back({2'b00, 8'hA5});
    send_8n1(8'hA5, 1'b1);
    gap(30);
    chk("a5_valid_cycles", valid_hi - v0, 1);
    exp_q.push_back({2'b00, 8'hFF});
    send_8n1(8'hFF, 1'b1);
    gap(20);
    exp_q.push_back({2'b00, 8'h00});
    send_8n1(8'h00, 1'b1);
    gap(20);
    exp_q.push_back({2'b10, 8'h3C});
    send_8n1(8'h3C, 1'b0);
    gap(30);
    chk("basic_drained", exp_q.size(), 0);

    // Even parity: 0x03 with parity 1 is wrong, 0x07 with parity 1 is right.
    exp_e.push_back({2'b01, 8'h03});
    send_bits(1, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
    gap(20);
    exp_e.push_back({2'b00, 8'h07});
    send_bits(1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    gap(30);
    chk("parity_drained", exp_e.size(), 0);

    // Short start glitch.
    v0 = valid_hi;
    c0 = busy_cyc;
    rx = 1'b0;
    gap(3);
    rx = 1'b1;
    gap(40);
    chk("glitch_no_valid", valid_hi - v0, 0);
    chk("glitch_left_idle", (busy_cyc - c0) > 0, 1);
    chk("glitch_idle", busy, 0);

    // Break: line low for 12 bit periods.
    v0 = valid_hi;
    b0 = brk_cnt;
    rx = 1'b0;
    gap(115);
    chk("brk_busy_hold", busy, 1);
    gap(5);
    rx = 1'b1;
    gap(8);
    chk("brk_pulses", brk_cnt - b0, 1);
    chk("brk_idle", busy, 0);
    chk("brk_no_word", valid_hi - v0, 0);

    // Overrun: four frames fill the FIFO, the fifth is dropped.
    ready = 1'b0;
    o0 = ovr_cnt;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({2'b00, 8'(8'h11 + i)});
      send_8n1(8'(8'h11 + i), 1'b1);
      gap(20);
    end
    chk("ovr_before_fifth", ovr_cnt - o0, 0);
    send_8n1(8'h15, 1'b1);
    gap(20);
    chk("ovr_fifth", ovr_cnt - o0, 1);
    chk("full_valid", valid, 1);
    ready = 1'b1;
    gap(10);
    chk("ovr_drained", exp_q.size(), 0);
    chk("ovr_empty", valid, 0);

    // Reset during the data bits of 0x5A, then a clean 0x3C.
    rx = 1'b0;
    gap(10);
    rx = 1'b0;
    gap(10);
    rx = 1'b1;
    gap(10);
    rx = 1'b0;
    gap(5);
    chk("mid_frame_busy", busy, 1);
    rst_n = 1'b0;
    gap(2);
    chk("mid_reset_busy", busy, 0);
    rx = 1'b1;
    gap(2);
    v0 = valid_hi;
    o0 = ovr_cnt;
    b0 = brk_cnt;
    rst_n = 1'b1;
    gap(30);
    chk("post_reset_no_valid", valid_hi - v0, 0);
    chk("post_reset_no_pulse", (ovr_cnt - o0) + (brk_cnt - b0), 0);
    exp_q.push_back({2'b00, 8'h3C});
    send_8n1(8'h3C, 1'b1);
    gap(30);
    chk("final_drained", exp_q.size(), 0);
    chk("final_drained_e", exp_e.size(), 0);
    chk("e_no_pulses", e_misc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_receive_cfg.md
UART_RECEIVE_CFG -- requirements
Module: uart_receive_cfg

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low (ports clk_in, rst_n_in).
REQ-002 Parameter INPUT_CLOCK_FREQ, 100_000_000: clock frequency in Hz.
REQ-003 Parameter BAUD_RATE, 57600: line bit rate.
REQ-004 Parameter DATA_BITS, 8: data bits per frame, legal range 5..9.
REQ-005 Parameter PARITY, 0: parity mode; 0 none, 1 odd, 2 even.
REQ-006 Parameter STOP_BITS, 1: number of stop bits, 1 or 2.
REQ-007 Parameter FIFO_DEPTH, 4: receive FIFO entries, power of two, >= 2.
REQ-008 clk_in  input  1  system clock.
REQ-009 rst_n_in  input  1  asynchronous active-low reset.
REQ-010 rx_wire_in  input  1  asynchronous serial line, idle high.
REQ-011 data_byte_out  output  DATA_BITS  FIFO head data word.
REQ-012 parity_err_out  output  1  FIFO head parity-error flag.
REQ-013 frame_err_out  output  1  FIFO head framing-error flag.
REQ-014 valid_out  output  1  FIFO non-empty; head outputs valid.
REQ-015 ready_in  input  1  consumer accepts head when high with valid_out.
REQ-016 overrun_out  output  1  one-cycle pulse: frame dropped, FIFO full.
REQ-017 break_out  output  1  one-cycle pulse: break condition detected.
REQ-018 busy_out  output  1  high whenever the FSM is not in IDLE.

Function
REQ-019 rx_wire_in SHALL pass through a 2-flop synchronizer; all logic uses the synchronized line.
REQ-020 Bit period BP = INPUT_CLOCK_FREQ/BAUD_RATE (integer division); bit counter runs 0..BP-1, wraps, held at 0 in IDLE/COMMIT/BRK.
REQ-021 Each bit value SHALL be the 2-of-3 majority of samples at counts BP/2-1, BP/2, BP/2+1, decided at BP/2+1.
REQ-022 FSM states: IDLE, START, DATA, PARITY, STOP, COMMIT, BRK.
REQ-023 IDLE -> START on a synchronized high-to-low transition, only once the line has been seen high at least one cycle since reset.
REQ-024 START: majority 0 -> DATA; majority 1 -> IDLE, nothing stored.
REQ-025 DATA: DATA_BITS bits shifted in LSB first; after last bit -> PARITY if PARITY!=0 else STOP.
REQ-026 PARITY: parity_err = received bit mismatches odd/even parity of data bits; with PARITY=0 parity_err is 0.
REQ-027 STOP: each of STOP_BITS bits sampled; any 0 sets frame_err; after last stop bit -> COMMIT, or BRK on break.
REQ-028 Break = all data bits 0, parity bit (if any) 0, first stop bit 0; break_out pulses, no word stored, BRK waits for line high, then IDLE.
REQ-029 COMMIT: push {frame_err, parity_err, data} into FIFO for one cycle, then IDLE; errored frames are stored, not dropped.
REQ-030 Push when FIFO full and no pop in the same cycle: word discarded, overrun_out pulses in the COMMIT cycle.
REQ-031 Simultaneous push and pop when full SHALL succeed with no overrun; simultaneous push and pop when empty SHALL leave the FIFO holding the new word.
REQ-032 Pop occurs on the rising edge where valid_out && ready_in; head outputs SHALL update the next cycle.
REQ-033 valid_out SHALL assert the cycle after COMMIT when the FIFO was empty.
REQ-034 Head outputs SHALL read 0 while valid_out is low.

Reset
REQ-035 rst_n_in low SHALL immediately force: FSM IDLE, counters 0, synchronizer flops 1, FIFO empty, every output 0.
REQ-036 Reset mid-frame SHALL discard the partial frame; no pulse appears on any output after release.

Structure
REQ-037 Package uart_pkg SHALL hold the FSM state enum, parity-mode enum/constants, and a bit-period function.
REQ-038 The FIFO SHALL be a separate sub-module uart_fifo (parameters WIDTH, DEPTH; push/pop/full/empty, synchronous read).
REQ-039 Parameter legality (DATA_BITS, PARITY, STOP_BITS, FIFO_DEPTH) SHALL be checked at elaboration.

Verification (INPUT_CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, BP=10)
REQ-040 8N1 frame 0xA5, ready_in=1 -> one valid_out cycle, data 0xA5, both error flags 0.
REQ-041 PARITY=2, 8E1 frame 0x03 with parity bit 1 -> data 0x03, parity_err_out=1, frame_err_out=0.
REQ-042 Start pulse low for 3 clocks only -> returns to IDLE, valid_out stays 0.
REQ-043 Line low for 12 bit periods then high -> break_out single pulse, no FIFO word, FSM IDLE after line high.
REQ-044 FIFO_DEPTH=4, ready_in=0, five frames 0x11..0x15 -> overrun_out pulse on the fifth; then pops yield 0x11,0x12,0x13,0x14.
REQ-045 rst_n_in low during DATA of frame 0x5A, released, then frame 0x3C -> only 0x3C delivered.
